// File: rtl/axil_slv2mem.sv
// AXI4-Lite slave that serves single-beat reads and writes from a synchronous single-port SRAM.
// One transaction is in flight at a time; rdPrio_q alternates priority between served writes and reads.
module axil_slv2mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 10
) (
  input  logic                    i_aclk,
  input  logic                    i_areset,
  input  logic                    i_s_awvalid,
  output logic                    o_s_awready,
  input  logic [ADDR_WIDTH-1:0]   i_s_awaddr,
  input  logic                    i_s_wvalid,
  output logic                    o_s_wready,
  input  logic [DATA_WIDTH-1:0]   i_s_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_s_wstrb,
  output logic                    o_s_bvalid,
  input  logic                    i_s_bready,
  output logic [1:0]              o_s_bresp,
  input  logic                    i_s_arvalid,
  output logic                    o_s_arready,
  input  logic [ADDR_WIDTH-1:0]   i_s_araddr,
  output logic                    o_s_rvalid,
  input  logic                    i_s_rready,
  output logic [DATA_WIDTH-1:0]   o_s_rdata,
  output logic [1:0]              o_s_rresp,
  output logic                    o_mem_cs,
  output logic                    o_mem_we,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  output logic [MEM_AW-1:0]       o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);
  localparam int StrbW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_ACC, WR_RESP, RD_ACC, RD_WAIT, RD_RESP} state_e;

  state_e                state_q, state_d;
  logic                  awCap_q, awCap_d, wCap_q, wCap_d, rdPrio_q, rdPrio_d;
  logic [ADDR_WIDTH-1:2] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wData_q, wData_d, rData_q, rData_d;
  logic [StrbW-1:0]      wStrb_q, wStrb_d;
  logic                  idleReady, addrErr, accState;
  logic                  awHs, wHs, arHs;
  logic                  unusedAddrLsbs;

  assign unusedAddrLsbs = ^{i_s_awaddr[1:0], i_s_araddr[1:0]};

  // Readies look only at state, capture flags and the other channels' valids.
  always_comb begin
    idleReady   = (state_q == IDLE) && !i_areset;
    o_s_awready = idleReady && !awCap_q && !(rdPrio_q && i_s_arvalid);
    o_s_wready  = idleReady && !wCap_q && !(rdPrio_q && i_s_arvalid);
    o_s_arready = idleReady && !awCap_q && !wCap_q &&
                  (rdPrio_q || (!i_s_awvalid && !i_s_wvalid));
    awHs        = i_s_awvalid && o_s_awready;
    wHs         = i_s_wvalid && o_s_wready;
    arHs        = i_s_arvalid && o_s_arready;
    addrErr     = |addr_q[ADDR_WIDTH-1:MEM_AW+2];
  end

  always_comb begin
    state_d  = state_q;
    awCap_d  = awCap_q;
    wCap_d   = wCap_q;
    rdPrio_d = rdPrio_q;
    addr_d   = addr_q;
    wData_d  = wData_q;
    wStrb_d  = wStrb_q;
    rData_d  = rData_q;
    case (state_q)
      IDLE: begin
        if (awHs) begin
          awCap_d = 1'b1;
          addr_d  = i_s_awaddr[ADDR_WIDTH-1:2];
        end
        if (wHs) begin
          wCap_d  = 1'b1;
          wData_d = i_s_wdata;
          wStrb_d = i_s_wstrb;
        end
        // Skip a bubble when the final write handshake lands this cycle.
        if ((awCap_q || awHs) && (wCap_q || wHs)) begin
          state_d = WR_ACC;
        end else if (arHs) begin
          addr_d  = i_s_araddr[ADDR_WIDTH-1:2];
          state_d = RD_ACC;
        end
      end
      WR_ACC: begin
        awCap_d  = 1'b0;
        wCap_d   = 1'b0;
        rdPrio_d = 1'b1;
        state_d  = WR_RESP;
      end
      WR_RESP: if (i_s_bready) state_d = IDLE;
      RD_ACC:  state_d = RD_WAIT;
      RD_WAIT: begin
        rData_d  = addrErr ? '0 : i_mem_rdata;
        rdPrio_d = 1'b0;
        state_d  = RD_RESP;
      end
      RD_RESP: if (i_s_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      state_q  <= IDLE;
      awCap_q  <= 1'b0;
      wCap_q   <= 1'b0;
      rdPrio_q <= 1'b0;
      addr_q   <= '0;
      wData_q  <= '0;
      wStrb_q  <= '0;
      rData_q  <= '0;
    end else begin
      state_q  <= state_d;
      awCap_q  <= awCap_d;
      wCap_q   <= wCap_d;
      rdPrio_q <= rdPrio_d;
      addr_q   <= addr_d;
      wData_q  <= wData_d;
      wStrb_q  <= wStrb_d;
      rData_q  <= rData_d;
    end
  end

  // Memory strobe is suppressed for out-of-range addresses and while reset is held.
  always_comb begin
    accState    = (state_q == WR_ACC) || (state_q == RD_ACC);
    o_mem_cs    = accState && !addrErr && !i_areset;
    o_mem_we    = (state_q == WR_ACC);
    o_mem_be    = (state_q == WR_ACC) ? wStrb_q : '0;
    o_mem_addr  = accState ? addr_q[MEM_AW+1:2] : '0;
    o_mem_wdata = (state_q == WR_ACC) ? wData_q : '0;
    o_s_bvalid  = (state_q == WR_RESP);
    o_s_bresp   = ((state_q == WR_RESP) && addrErr) ? 2'b10 : 2'b00;
    o_s_rvalid  = (state_q == RD_RESP);
    o_s_rresp   = ((state_q == RD_RESP) && addrErr) ? 2'b10 : 2'b00;
    o_s_rdata   = rData_q;
  end

endmodule
